lab3_cache_mem_bridge: RTL and testbench

//  Memory-side stage directly downstream of lab3_cache_CacheBase: consumes the cache's cache_req stream
//  (16x 4B reads per refill, 16x 4B writes per evict/flush) and returns read data on cache_resp.

---
 rtl/lab3_cache_mem_bridge_pkg.sv | 17 +
 rtl/lab3_cache_MemBridgeQueue.sv | 42 ++++
 rtl/lab3_cache_mem_bridge.sv | 78 +++++++
 tb/tb_lab3_cache_mem_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_cache_mem_bridge_pkg.sv
// lab3_cache_mem_bridge_pkg: message field positions, type codes and counter sizing for the memory bridge.
package lab3_cache_mem_bridge_pkg;

    localparam int c_req_w  = 77;
    localparam int c_resp_w = 47;

    // type_ sits in the top three bits of both mem_req_4B_t and mem_resp_4B_t
    localparam int c_resp_type_lsb = 44;

    localparam logic [2:0] c_read  = 3'd0;
    localparam logic [2:0] c_write = 3'd1;

    function automatic int outstand_w(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/lab3_cache_MemBridgeQueue.sv
// lab3_cache_MemBridgeQueue: val/rdy FIFO with wrap-bit pointers for full/empty detection.
module lab3_cache_MemBridgeQueue #(
    parameter int p_depth = 4,
    parameter int p_width = 77
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_msg
);

    localparam int aw = $clog2(p_depth);

    logic [aw:0]        wr_ptr, rd_ptr;
    logic [p_width-1:0] mem [p_depth];
    logic               push, pop;

    assign enq_rdy = !((wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]));
    assign deq_val = wr_ptr != rd_ptr;
    assign deq_msg = mem[rd_ptr[aw-1:0]];
    assign push    = enq_val && enq_rdy;
    assign pop     = deq_val && deq_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (aw+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[aw-1:0]] <= enq_msg;
    end

endmodule

// File: rtl/lab3_cache_mem_bridge.sv
// lab3_cache_mem_bridge: buffers cache memory requests, caps in-flight transactions and
// forwards only read data back to the cache, absorbing write-class acks.
module lab3_cache_mem_bridge
    import lab3_cache_mem_bridge_pkg::*;
#(
    parameter int p_req_depth    = 4,
    parameter int p_resp_depth   = 2,
    parameter int p_max_outstand = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cache_req_val,
    output logic                cache_req_rdy,
    input  logic [c_req_w-1:0]  cache_req_msg,
    output logic                cache_resp_val,
    input  logic                cache_resp_rdy,
    output logic [c_resp_w-1:0] cache_resp_msg,
    output logic                mem_req_val,
    input  logic                mem_req_rdy,
    output logic [c_req_w-1:0]  mem_req_msg,
    input  logic                mem_resp_val,
    output logic                mem_resp_rdy,
    input  logic [c_resp_w-1:0] mem_resp_msg,
    output logic                idle,
    output logic                err
);

    localparam int              ow      = outstand_w(p_max_outstand);
    localparam logic [ow-1:0]   max_cnt = ow'(p_max_outstand);

    logic [ow-1:0] outstand;
    logic          req_head_val, resp_enq_rdy, resp_deq_val;
    logic          is_read, none, issue, resp_acc, retire;

    lab3_cache_MemBridgeQueue #(.p_depth(p_req_depth), .p_width(c_req_w)) req_q (
        .clk     (clk),
        .reset   (reset),
        .enq_val (cache_req_val),
        .enq_rdy (cache_req_rdy),
        .enq_msg (cache_req_msg),
        .deq_val (req_head_val),
        .deq_rdy (issue),
        .deq_msg (mem_req_msg)
    );

    lab3_cache_MemBridgeQueue #(.p_depth(p_resp_depth), .p_width(c_resp_w)) resp_q (
        .clk     (clk),
        .reset   (reset),
        .enq_val (mem_resp_val && is_read && !none),
        .enq_rdy (resp_enq_rdy),
        .enq_msg (mem_resp_msg),
        .deq_val (resp_deq_val),
        .deq_rdy (cache_resp_rdy),
        .deq_msg (cache_resp_msg)
    );

    assign is_read        = mem_resp_msg[c_resp_type_lsb +: 3] == c_read;
    assign none           = outstand == '0;
    // a stray response (nothing outstanding) is always swallowed so memory can never deadlock on it
    assign mem_resp_rdy   = none || !is_read || resp_enq_rdy;
    assign resp_acc       = mem_resp_val && mem_resp_rdy;
    assign retire         = resp_acc && !none;
    assign mem_req_val    = req_head_val && (outstand < max_cnt);
    assign issue          = mem_req_val && mem_req_rdy;
    assign cache_resp_val = resp_deq_val;
    assign idle           = !req_head_val && none && !resp_deq_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstand <= '0;
            err      <= 1'b0;
        end else begin
            outstand <= outstand + ow'(issue) - ow'(retire);
            err      <= err || (resp_acc && none);
        end
    end

endmodule

// File: tb/tb_lab3_cache_mem_bridge.sv
// tb_lab3_cache_mem_bridge: directed checks of reset, refill, writeback absorb, throttling,
// response backpressure and the stray-response error flag.
module tb_lab3_cache_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cache_req_val = 1'b0, cache_req_rdy;
    logic [76:0] cache_req_msg = '0;
    logic        cache_resp_val, cache_resp_rdy = 1'b0;
    logic [46:0] cache_resp_msg;
    logic        mem_req_val, mem_req_rdy = 1'b0;
    logic [76:0] mem_req_msg;
    logic        mem_resp_val = 1'b0, mem_resp_rdy;
    logic [46:0] mem_resp_msg = '0;
    logic        idle, err;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf_base = {21'd15, 5'd2, 6'd0};
    logic [31:0] wb_base = {21'd7, 5'd2, 6'd0};

    always #5 clk = ~clk;

    lab3_cache_mem_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .cache_req_val  (cache_req_val),
        .cache_req_rdy  (cache_req_rdy),
        .cache_req_msg  (cache_req_msg),
        .cache_resp_val (cache_resp_val),
        .cache_resp_rdy (cache_resp_rdy),
        .cache_resp_msg (cache_resp_msg),
        .mem_req_val    (mem_req_val),
        .mem_req_rdy    (mem_req_rdy),
        .mem_req_msg    (mem_req_msg),
        .mem_resp_val   (mem_resp_val),
        .mem_resp_rdy   (mem_resp_rdy),
        .mem_resp_msg   (mem_resp_msg),
        .idle           (idle),
        .err            (err)
    );

    function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [31:0] addr, input logic [31:0] data);
        return {t, 8'h00, addr, 2'd0, data};
    endfunction

    function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [31:0] data);
        return {t, 8'h00, 2'd0, 2'd0, data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cache_req_val = 1'b0;
        mem_req_rdy = 1'b0;
        mem_resp_val = 1'b0;
        cache_resp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        chk("rst_req_rdy", cache_req_rdy, 1);
        chk("rst_mem_req_val", mem_req_val, 0);
        chk("rst_resp_val", cache_resp_val, 0);
        chk("rst_mem_resp_rdy", mem_resp_rdy, 1);
        reset = 1'b1;
        cyc();
    endtask

    // offers n requests and lets memory take them; checks addresses in issue order
    task automatic push(input int n, input int exp_iss, input logic [2:0] t, input logic [31:0] base);
        int sent = 0;
        int iss = 0;
        mem_req_rdy = 1'b1;
        for (int c = 0; c < 80 && (sent < n || iss < exp_iss); c++) begin
            cache_req_val = sent < n;
            cache_req_msg = mk_req(t, base + 32'(4 * sent), 32'(sent));
            #1;
            if (mem_req_val) begin
                chk("issue_addr", mem_req_msg[65:34], base + 32'(4 * iss));
                iss++;
            end
            if (cache_req_val && cache_req_rdy) sent++;
            cyc();
        end
        cache_req_val = 1'b0;
        mem_req_rdy = 1'b0;
        chk("sent", sent, n);
        chk("issued", iss, exp_iss);
    endtask

    initial begin
        do_reset();

        // refill: 16 reads, data i returned in order
        push(16, 16, 3'd0, rf_base);
        cache_resp_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = mk_resp(3'd0, 32'(i));
            #1;
            chk("refill_mem_resp_rdy", mem_resp_rdy, 1);
            chk("refill_busy", idle, 0);
            if (i > 0) begin
                chk("refill_val", cache_resp_val, 1);
                chk("refill_data", cache_resp_msg[31:0], 32'(i - 1));
            end
            cyc();
        end
        mem_resp_val = 1'b0;
        #1;
        chk("refill_last_val", cache_resp_val, 1);
        chk("refill_last_data", cache_resp_msg[31:0], 32'd15);
        chk("refill_busy_last", idle, 0);
        cyc();
        chk("refill_idle", idle, 1);
        chk("refill_drained", cache_resp_val, 0);

        // writeback: acks absorbed, idle only after the 16th
        push(16, 16, 3'd1, wb_base);
        for (int i = 0; i < 16; i++) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = mk_resp(3'd1, 32'(i));
            #1;
            chk("wb_mem_resp_rdy", mem_resp_rdy, 1);
            chk("wb_no_fwd", cache_resp_val, 0);
            chk("wb_busy", idle, 0);
            cyc();
        end
        mem_resp_val = 1'b0;
        #1;
        chk("wb_idle", idle, 1);
        chk("wb_no_fwd_end", cache_resp_val, 0);

        // throttle: 16 in flight, 4 queued
        push(20, 16, 3'd0, rf_base);
        chk("thr_req_val", mem_req_val, 0);
        chk("thr_req_rdy", cache_req_rdy, 0);
        cache_resp_rdy = 1'b0;
        mem_req_rdy = 1'b1;
        mem_resp_val = 1'b1;
        mem_resp_msg = mk_resp(3'd0, 32'h55);
        #1;
        chk("thr_resp_rdy", mem_resp_rdy, 1);
        chk("thr_held", mem_req_val, 0);
        cyc();
        mem_resp_val = 1'b0;
        #1;
        chk("thr_reissue", mem_req_val, 1);
        chk("thr_fwd_val", cache_resp_val, 1);
        chk("thr_fwd_data", cache_resp_msg[31:0], 32'h55);
        cyc();
        chk("thr_full_again", mem_req_val, 0);
        do_reset();

        // backpressure: response FIFO holds 2
        push(3, 3, 3'd0, rf_base);
        for (int i = 0; i < 2; i++) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = mk_resp(3'd0, 32'hA0 + 32'(i));
            #1;
            chk("bp_accept", mem_resp_rdy, 1);
            cyc();
        end
        mem_resp_msg = mk_resp(3'd0, 32'hA2);
        #1;
        chk("bp_stall", mem_resp_rdy, 0);
        chk("bp_head", cache_resp_msg[31:0], 32'hA0);
        cyc();
        chk("bp_stall_hold", mem_resp_rdy, 0);
        cache_resp_rdy = 1'b1;
        #1;
        chk("bp_pop0_data", cache_resp_msg[31:0], 32'hA0);
        cyc();
        chk("bp_release", mem_resp_rdy, 1);
        chk("bp_pop1_data", cache_resp_msg[31:0], 32'hA1);
        cyc();
        mem_resp_val = 1'b0;
        #1;
        chk("bp_pop2_val", cache_resp_val, 1);
        chk("bp_pop2_data", cache_resp_msg[31:0], 32'hA2);
        cyc();
        chk("bp_idle", idle, 1);

        // stray response sets err and is dropped
        mem_resp_val = 1'b1;
        mem_resp_msg = mk_resp(3'd0, 32'h77);
        #1;
        chk("err_resp_rdy", mem_resp_rdy, 1);
        cyc();
        mem_resp_val = 1'b0;
        #1;
        chk("err_set", err, 1);
        chk("err_no_fwd", cache_resp_val, 0);
        chk("err_idle", idle, 1);

        // reset mid-refill with 8 outstanding
        push(8, 8, 3'd0, rf_base);
        chk("mid_busy", idle, 0);
        chk("mid_err_sticky", err, 1);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
